wb_write_sequencer: RTL
=======================

# wb_write_sequencer

Write-back sequencer that drives the write side of the 16x16 register file (`register`). It accepts execution results through a valid/ready handshake and buffers them in a small FIFO. It issues them as `registerWrite`/`regWriteLocal`/`dataWrite`/`r0Write` commands, one per cycle. It also forwards still-pending values to the decode-stage read path, so reads issued while a write is queued return current data.

## Interface
- `DATA_W`, 16, register data width
- `ADDR_W`, 4, register address width
- `DEPTH`, 2, FIFO entries; power of two, >= 2
- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `resValid`  in  1  result offered this cycle
- `resReady`  out  1  block can accept a result
- `resOp`  in  2  00 none, 01 write Rd, 10 write R0, 11 write Rd and R0
- `resDest`  in  ADDR_W  destination register Rd
- `resData`  in  DATA_W  value for Rd
- `resR0Data`  in  DATA_W  value for R0
- `stall`  in  1  suppress write issue this cycle
- `registerWrite`  out  2  write command to register file; same encoding as `resOp`
- `regWriteLocal`  out  ADDR_W  write address
- `dataWrite`  out  DATA_W  Rd write data
- `r0Write`  out  DATA_W  R0 write data
- `fwdAddr1`, `fwdAddr2`  in  ADDR_W  read addresses presented to the register file
- `fwdRaw1`, `fwdRaw2`  in  DATA_W  register file `dataRead1`/`dataRead2`
- `fwdData1`, `fwdData2`  out  DATA_W  forwarded read data
- `pending`  out  clog2(DEPTH)+1  number of queued entries

## Operation
**Accept**
- A handshake occurs when `resValid && resReady`.
- `resOp`=00 is accepted and discarded; no entry is created.
- `resOp`=11 with `resDest`=0 is stored as 10. The R0 value wins.
- `resReady` = `reset_n && (pending < DEPTH)`. It is combinational from registered count, not from `stall`.
- When full, `resReady`=0 even if a pop occurs in the same cycle. There is no push-through-on-pop.

**Storage**
- Circular FIFO. Each entry holds {op, dest, data, r0data}.
- Read and write pointers wrap modulo DEPTH.
- Entries issue in strict order.

**Issue**
- When `pending`>0 and `stall`=0:
  - `registerWrite` = head op; `regWriteLocal`, `dataWrite`, `r0Write` = head fields.
  - The head pops at the clock edge.
- Otherwise `registerWrite`=00, and the data and address outputs still show head fields.
- The data and address outputs are don't-care to the register file when `registerWrite`=00, but must be deterministic (head fields, or 0 after reset).

**Forwarding** (independent per port; combinational)
- Candidates are all valid entries, including the head issuing this cycle.
- An entry matches address A if either holds:
  - (op[0] and dest==A): supplies data.
  - (op[1] and A==0): supplies r0data.
- The newest matching entry wins. If there is no match, output `fwdRaw`.

**Reset** (`reset_n` low at an edge)
- Pointers and count are cleared to 0. All entry fields are cleared to 0.
- Outputs after that edge: `registerWrite`=00, `regWriteLocal`=0, `dataWrite`=0, `r0Write`=0, `pending`=0.
- `resReady`=0 while `reset_n` is low.
- `fwdData1`/`fwdData2` = `fwdRaw1`/`fwdRaw2`.
- Reset during pending writes discards them; no write is issued in the reset cycle.

## Timing
- Result accepted at edge N with the FIFO empty and `stall`=0:
  - Write command is visible in cycle N..N+1.
  - Register file commits at edge N+1.
- Forwarding covers the gap from edge N until the commit at edge N+1, and beyond if stalled.
- Throughput: one write per cycle while not stalled.
- A sustained stream with no `stall` never fills a DEPTH>=2 FIFO.
- Simultaneous push and pop when neither empty nor full: count unchanged; the new entry goes to the tail.
- Simultaneous push and pop when empty: push only. The pop condition requires `pending`>0 at the start of the cycle.
- `stall` acts only on issue; it never blocks acceptance while space remains.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with `resValid`=1 -> `resReady`=0, `registerWrite`=00, `pending`=0. Release -> `resReady`=1.
- **Single Rd write:** op 01, dest 3, data 16'h4020 -> next cycle `registerWrite`=01, `regWriteLocal`=3, `dataWrite`=16'h4020. After the edge `pending`=0, and register 3 reads 16'h4020.
- **Stall and full:**
  - Setup: `stall`=1. Push op 10 with r0 16'h1239, then op 01 with dest 5 and 16'hBEEF.
  - Expect after the two pushes: `pending`=2 and `resReady`=0. A third push is not accepted.
  - Release `stall`: `registerWrite`=10 with `r0Write`=16'h1239, then 01 with `regWriteLocal`=5.
- **Forwarding priority:**
  - Setup: `stall`=1. Queue dest 4 = 16'h0001, then dest 4 = 16'h0002. Set `fwdAddr1`=4 and `fwdRaw1`=16'hFFFF.
  - Expect `fwdData1`=16'h0002.
  - Set `fwdAddr2`=0 with no R0 entry queued: `fwdData2`=`fwdRaw2`.
- **Dual write and dest-0 rule:**
  - Op 11, dest 2, data 16'h00AA, r0 16'h5500 -> `registerWrite`=11, both registers updated.
  - Op 11, dest 0 -> issued as 10.
  - Op 00 -> accepted, `pending` unchanged.
- **Reset mid-operation:** two entries queued under `stall` -> assert `reset_n`=0 for one edge -> `pending`=0, no write issued, `fwdData1`=`fwdRaw1`.

Source files
------------

// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: buffers execution results in a small circular FIFO,
// issues them to the register file one per cycle, and forwards queued values
// onto the decode-stage read ports so reads never see stale data.
module wb_write_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        resValid,
    output logic                        resReady,
    input  logic [1:0]                  resOp,
    input  logic [ADDR_W-1:0]           resDest,
    input  logic [DATA_W-1:0]           resData,
    input  logic [DATA_W-1:0]           resR0Data,
    input  logic                        stall,
    output logic [1:0]                  registerWrite,
    output logic [ADDR_W-1:0]           regWriteLocal,
    output logic [DATA_W-1:0]           dataWrite,
    output logic [DATA_W-1:0]           r0Write,
    input  logic [ADDR_W-1:0]           fwdAddr1,
    input  logic [ADDR_W-1:0]           fwdAddr2,
    input  logic [DATA_W-1:0]           fwdRaw1,
    input  logic [DATA_W-1:0]           fwdRaw2,
    output logic [DATA_W-1:0]           fwdData1,
    output logic [DATA_W-1:0]           fwdData2,
    output logic [$clog2(DEPTH):0]      pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Entry storage, one field per array
    logic [1:0]        op_q   [DEPTH];
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] r0_q   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       push;
    logic       pop;
    logic [1:0] push_op;

    // Ready comes only from the registered count; a same-cycle pop never frees space.
    assign resReady = reset_n && (count_q < DEPTH_C);
    // Op 00 handshakes but creates no entry.
    assign push     = resValid && resReady && (resOp != 2'b00);
    // Issue needs an entry present at the start of the cycle; never during reset.
    assign pop      = reset_n && !stall && (count_q != '0);
    // A dual write aimed at R0 collapses to an R0-only write so the R0 value wins.
    assign push_op  = ((resOp == 2'b11) && (resDest == '0)) ? 2'b10 : resOp;

    // Next-state pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers and entry writes; reset wipes every field
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                data_q[i] <= '0;
                r0_q[i]   <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                op_q[wr_ptr_q]   <= push_op;
                dest_q[wr_ptr_q] <= resDest;
                data_q[wr_ptr_q] <= resData;
                r0_q[wr_ptr_q]   <= resR0Data;
            end
        end
    end

    // Head entry drives the write port; the command is 00 unless it is popping
    always_comb begin
        registerWrite = pop ? op_q[rd_ptr_q] : 2'b00;
        regWriteLocal = dest_q[rd_ptr_q];
        dataWrite     = data_q[rd_ptr_q];
        r0Write       = r0_q[rd_ptr_q];
        pending       = count_q;
    end

    // Walk valid entries oldest to newest so the newest match overrides.
    function automatic logic [DATA_W-1:0] fwd_lookup(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] raw
    );
        logic [DATA_W-1:0] res;
        logic [PTR_W-1:0]  idx;
        res = raw;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (reset_n && (CNT_W'(i) < count_q)) begin
                if (op_q[idx][1] && (addr == '0))
                    res = r0_q[idx];
                if (op_q[idx][0] && (dest_q[idx] == addr))
                    res = data_q[idx];
            end
        end
        return res;
    endfunction

    // Independent forwarding mux per read port
    always_comb begin
        fwdData1 = fwd_lookup(fwdAddr1, fwdRaw1);
        fwdData2 = fwd_lookup(fwdAddr2, fwdRaw2);
    end

endmodule
